// File: rtl/mod_mul_pkg.sv
// rtl/mod_mul_pkg.sv - shared constants and FSM encoding for the serial modular multiplier
package mod_mul_pkg;

  localparam int DEFAULT_WIDTH = 256;

  localparam logic [255:0] SM2_P =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
  localparam logic [255:0] SM2_N =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_7203DF6B_21C6052B_53BBF409_39D54123;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/mod_dbl_add_step.sv
// rtl/mod_dbl_add_step.sv - one interleaved step: acc' = (2*acc + (sel ? b : 0)) mod m
module mod_dbl_add_step #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  input  logic             sel,
  output logic [WIDTH-1:0] acc_next
);

  logic [WIDTH+1:0] t;
  logic [WIDTH+1:0] m1;
  logic [WIDTH+1:0] m2;

  // acc < m and b < m keep t below 3m, so one of two subtractions suffices
  always_comb begin
    m1 = {2'b00, m};
    m2 = {1'b0, m, 1'b0};
    t  = {1'b0, acc, 1'b0} + (sel ? {2'b00, b} : '0);
    if (t >= m2) begin
      acc_next = WIDTH'(t - m2);
    end else if (t >= m1) begin
      acc_next = WIDTH'(t - m1);
    end else begin
      acc_next = WIDTH'(t);
    end
  end

endmodule

// File: rtl/mod_mul_serial.sv
// rtl/mod_mul_serial.sv - bit-serial interleaved a*b mod m; MOD_MUL_RANGE_CHECK_EN enables operand range errors
module mod_mul_serial
  import mod_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld_i,
  output logic             in_rdy_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] m_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_vld_o,
  input  logic             out_rdy_i,
  output logic [WIDTH-1:0] r_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             err_o
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] m_q;
  logic [TAG_W-1:0] tag_q;
  logic             range_bad;
  logic             err_q;

  assign in_rdy_o  = (state == ST_IDLE);
  assign out_vld_o = (state == ST_DONE);

  mod_dbl_add_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .b        (b_q),
    .m        (m_q),
    .sel      (a_q[cnt]),
    .acc_next (acc_next)
  );

`ifdef MOD_MUL_RANGE_CHECK_EN
  // Checked on the latched operands during the first RUN cycle
  assign range_bad = (a_q >= m_q) || (b_q >= m_q) || (m_q < WIDTH'(2));
  assign err_o     = err_q;
`else
  assign range_bad = 1'b0;
  assign err_o     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      acc   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      m_q   <= '0;
      tag_q <= '0;
      r_o   <= '0;
      tag_o <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_vld_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            m_q   <= m_i;
            tag_q <= tag_i;
            acc   <= '0;
            cnt   <= CW'(WIDTH - 1);
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (range_bad) begin
            r_o   <= '0;
            tag_o <= tag_q;
            err_q <= 1'b1;
            state <= ST_DONE;
          end else begin
            acc <= acc_next;
            cnt <= cnt - CW'(1);
            if (cnt == '0) begin
              r_o   <= acc_next;
              tag_o <= tag_q;
              err_q <= 1'b0;
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (out_rdy_i) begin
            err_q <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mul_serial.sv
// tb/tb_mod_mul_serial.sv - self-checking bench for mod_mul_serial at WIDTH=8 and WIDTH=256
module tb_mod_mul_serial;
  import mod_mul_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         vld8 = 0, irdy8, ov8, ordy8 = 0, err8;
  logic [7:0]   a8 = 0, b8 = 0, m8 = 0, r8;
  logic [3:0]   tagi8 = 0, tago8;
  logic         vld2 = 0, irdy2, ov2, ordy2 = 0, err2;
  logic [255:0] a2 = 0, b2 = 0, m2 = 0, r2;
  logic [3:0]   tagi2 = 0, tago2;

  int checks = 0;
  int failures = 0;

  mod_mul_serial #(.WIDTH(8), .TAG_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_vld_i(vld8), .in_rdy_o(irdy8),
    .a_i(a8), .b_i(b8), .m_i(m8), .tag_i(tagi8),
    .out_vld_o(ov8), .out_rdy_i(ordy8), .r_o(r8), .tag_o(tago8), .err_o(err8)
  );

  mod_mul_serial #(.WIDTH(256), .TAG_W(4)) u_dut256 (
    .clk(clk), .rst(rst), .in_vld_i(vld2), .in_rdy_o(irdy2),
    .a_i(a2), .b_i(b2), .m_i(m2), .tag_i(tagi2),
    .out_vld_o(ov2), .out_rdy_i(ordy2), .r_o(r2), .tag_o(tago2), .err_o(err2)
  );

  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Reference: plain double-width product and remainder
  function automatic logic [255:0] ref_mul(input logic [255:0] a, input logic [255:0] b,
                                           input logic [255:0] m);
    logic [511:0] p;
    logic [511:0] q;
    p = {256'b0, a} * {256'b0, b};
    q = p % {256'b0, m};
    return q[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic issue(input bit big, input logic [255:0] a, input logic [255:0] b,
                       input logic [255:0] m, input logic [3:0] tag);
    @(negedge clk);
    chk("in_rdy_before_accept", 256'(big ? irdy2 : irdy8), 256'(1));
    if (big) begin
      a2 = a; b2 = b; m2 = m; tagi2 = tag; vld2 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; m8 = m[7:0]; tagi8 = tag; vld8 = 1'b1;
    end
    @(negedge clk);
    vld8 = 1'b0;
    vld2 = 1'b0;
  endtask

  task automatic await_result(input bit big, input logic [255:0] exp_r, input logic [3:0] exp_tag,
                              input logic exp_err, input int exp_lat, input int stall);
    int cyc;
    cyc = 0;
    while (!(big ? ov2 : ov8) && cyc < 600) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", 256'(cyc), 256'(exp_lat));
    chk("result", big ? r2 : 256'(r8), exp_r);
    chk("tag", 256'(big ? tago2 : tago8), 256'(exp_tag));
    chk("err", 256'(big ? err2 : err8), 256'(exp_err));
    if (stall > 0) begin
      if (big) begin
        a2 = 256'd1; b2 = 256'd1; m2 = 256'd3; tagi2 = ~exp_tag; vld2 = 1'b1;
      end else begin
        a8 = 8'd1; b8 = 8'd1; m8 = 8'd3; tagi8 = ~exp_tag; vld8 = 1'b1;
      end
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("stall_result", big ? r2 : 256'(r8), exp_r);
        chk("stall_tag", 256'(big ? tago2 : tago8), 256'(exp_tag));
        chk("stall_vld", 256'(big ? ov2 : ov8), 256'(1));
        chk("stall_in_rdy", 256'(big ? irdy2 : irdy8), 256'(0));
      end
      vld8 = 1'b0;
      vld2 = 1'b0;
    end
    if (big) ordy2 = 1'b1; else ordy8 = 1'b1;
    @(negedge clk);
    ordy8 = 1'b0;
    ordy2 = 1'b0;
    chk("vld_after_handshake", 256'(big ? ov2 : ov8), 256'(0));
    chk("in_rdy_after_handshake", 256'(big ? irdy2 : irdy8), 256'(1));
    chk("err_after_handshake", 256'(big ? err2 : err8), 256'(0));
  endtask

  initial begin
    logic [255:0] a, b, m;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_rdy8", 256'(irdy8), 256'(1));
    chk("rst_out_vld8", 256'(ov8), 256'(0));
    chk("rst_r8", 256'(r8), 256'(0));
    chk("rst_tag8", 256'(tago8), 256'(0));
    chk("rst_err8", 256'(err8), 256'(0));
    chk("rst_in_rdy256", 256'(irdy2), 256'(1));
    chk("rst_out_vld256", 256'(ov2), 256'(0));
    chk("rst_r256", r2, 256'(0));

    issue(0, 256'd200, 256'd100, 256'd251, 4'd5);
    await_result(0, 256'd171, 4'd5, 1'b0, 8, 0);
    issue(0, 256'd250, 256'd250, 256'd251, 4'd6);
    await_result(0, 256'd1, 4'd6, 1'b0, 8, 0);
    issue(0, 256'd0, 256'd123, 256'd251, 4'd3);
    await_result(0, 256'd0, 4'd3, 1'b0, 8, 0);

    for (int i = 0; i < 20; i++) begin
      m = 256'($urandom_range(255, 2));
      a = 256'($urandom % m[31:0]);
      b = 256'($urandom % m[31:0]);
      issue(0, a, b, m, 4'(i));
      await_result(0, ref_mul(a, b, m), 4'(i), 1'b0, 8, 0);
    end

    issue(0, 256'd200, 256'd100, 256'd251, 4'd7);
    await_result(0, 256'd171, 4'd7, 1'b0, 8, 5);

    issue(0, 256'd77, 256'd99, 256'd251, 4'd9);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_rst_out_vld", 256'(ov8), 256'(0));
    chk("midrun_rst_in_rdy", 256'(irdy8), 256'(1));
    chk("midrun_rst_r", 256'(r8), 256'(0));
    chk("midrun_rst_tag", 256'(tago8), 256'(0));
    issue(0, 256'd3, 256'd5, 256'd251, 4'd2);
    await_result(0, 256'd15, 4'd2, 1'b0, 8, 0);

    issue(1, SM2_P - 256'd1, SM2_P - 256'd1, SM2_P, 4'd10);
    await_result(1, 256'd1, 4'd10, 1'b0, 256, 0);
    issue(1, 256'd2, (SM2_P + 256'd1) >> 1, SM2_P, 4'd11);
    await_result(1, 256'd1, 4'd11, 1'b0, 256, 0);
    for (int i = 0; i < 3; i++) begin
      m = (i == 0) ? SM2_N : (rand256() | 256'd2);
      a = rand256() % m;
      b = rand256() % m;
      issue(1, a, b, m, 4'(12 + i));
      await_result(1, ref_mul(a, b, m), 4'(12 + i), 1'b0, 256, 2);
    end

`ifdef MOD_MUL_RANGE_CHECK_EN
    issue(0, 256'd251, 256'd5, 256'd251, 4'd4);
    await_result(0, 256'd0, 4'd4, 1'b1, 1, 0);
    issue(0, 256'd1, 256'd1, 256'd1, 4'd8);
    await_result(0, 256'd0, 4'd8, 1'b1, 1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
